alu_uart_if: RTL
================

# alu_uart_if

Byte-stream front end for the `alu` block. It collects three bytes from the UART receiver (operand A, operand B, opcode) and drives them onto the ALU inputs. It then captures the ALU result and hands it to the UART transmitter with a start/done handshake. It sits between `uart_rx`/`uart_tx` and `alu` at the top level; the ALU itself stays purely combinational.

## Interface
- NB_DATA, 8, width of operands, result and UART bytes
- NB_OP, 6, width of the ALU opcode (MIPS funct field)

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte, valid only while i_rx_done is high
- i_rx_done  in  1  one-cycle pulse, byte received
- o_dato_a  out  NB_DATA  operand A to ALU
- o_dato_b  out  NB_DATA  operand B to ALU
- o_operation  out  NB_OP  opcode to ALU
- i_alu_result  in  NB_DATA  combinational ALU result
- o_tx_data  out  NB_DATA  byte to transmitter
- o_tx_start  out  1  one-cycle pulse, start transmission
- i_tx_done  in  1  one-cycle pulse, transmitter finished
- o_busy  out  1  high while a result is being computed or sent
- o_drop  out  1  one-cycle pulse, a received byte was discarded

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, CALC, WAIT_TX. Reset state is WAIT_A.
- WAIT_A, on i_rx_done: o_dato_a <= i_rx_data; go to WAIT_B.
- WAIT_B, on i_rx_done: o_dato_b <= i_rx_data; go to WAIT_OP.
- WAIT_OP, on i_rx_done: o_operation <= i_rx_data[NB_OP-1:0]; go to CALC.
- CALC (always exactly one cycle):
  - o_tx_data <= i_alu_result
  - o_tx_start <= 1
  - go to WAIT_TX
- WAIT_TX, on i_tx_done: go to WAIT_A. i_tx_done is ignored in the cycle where o_tx_start is high.
- Any other state ignores i_tx_done.
- o_dato_a, o_dato_b and o_operation hold their values until they are overwritten by the next frame. The ALU output therefore stays stable through transmission.
- In CALC and WAIT_TX, an i_rx_done pulse discards the byte and pulses o_drop for one cycle. This includes i_rx_done and i_tx_done arriving in the same WAIT_TX cycle: the byte is dropped and the state still goes to WAIT_A.
- o_busy = (state == CALC) | (state == WAIT_TX).
- Arithmetic is entirely inside the ALU. This block does no width extension; result bits beyond NB_DATA do not exist.

## Timing
- All outputs are registered.
- Reset values: o_dato_a = 0, o_dato_b = 0, o_operation = 0, o_tx_data = 0, o_tx_start = 0, o_busy = 0, o_drop = 0.
- Reset asserted mid-frame or mid-transmission: the FSM returns to WAIT_A immediately and partially received operands are lost. An in-flight transmission is not aborted by this block.
- Opcode byte sampled at edge k:
  - o_operation updates at edge k
  - o_tx_data and o_tx_start are set at edge k+1
  - o_tx_start clears at edge k+2
- i_rx_done pulses on consecutive cycles are each accepted in turn.

## Configuration
- ALU_IF_OPCHECK_EN defined:
  - In WAIT_OP, a byte is accepted only if it equals one of 0x20 (ADD), 0x22 (SUB), 0x24 (AND), 0x25 (OR), 0x26 (XOR), 0x27 (NOR), 0x03 (SRA) or 0x02 (SRL). Bits [7:6] must be 0.
  - Any other byte is dropped with an o_drop pulse, the FSM stays in WAIT_OP, and o_operation is unchanged.
- ALU_IF_OPCHECK_EN undefined: every opcode byte is accepted, bits above NB_OP are ignored, and o_drop never pulses in WAIT_OP.

## Test plan
- Frame 0x05, 0x03, 0x20 -> o_operation = 0x20, o_tx_data = 0x08, and o_tx_start is a single pulse one cycle after the opcode edge. After an i_tx_done pulse, o_busy = 0.
- Frame 0x05, 0x07, 0x22 -> o_tx_data = 0xFE. Next frame 0xF0, 0x3C, 0x27 -> o_tx_data = 0x03.
- Bytes 0xAA and 0x55 received in WAIT_TX -> o_drop pulses twice and o_dato_a/o_dato_b are unchanged. The next frame after i_tx_done is processed normally.
- i_rst_n low after only A = 0x11 was received -> all outputs are 0 and the state is WAIT_A. The next frame 0x01, 0x01, 0x24 -> o_tx_data = 0x01.
- With ALU_IF_OPCHECK_EN: opcode 0x21 -> o_drop pulse, no o_tx_start. A following 0x25 -> result sent. Without the macro, 0xE5 -> o_operation = 0x25.

Source files
------------

// File: rtl/alu_uart_if.sv
// Byte-stream front end for the alu: collects A, B, opcode from uart_rx and
// sends the result to uart_tx. Optional opcode filter: ALU_IF_OPCHECK_EN.
module alu_uart_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_OP-1:0]   o_operation,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_drop
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        CALC,
        WAIT_TX
    } state_t;

    state_t state;
    logic   op_ok;

`ifdef ALU_IF_OPCHECK_EN
    // Upper bits must be zero, so the whole byte is matched.
    always_comb begin
        op_ok = 1'b0;
        case (i_rx_data)
            NB_DATA'(8'h20), NB_DATA'(8'h22),
            NB_DATA'(8'h24), NB_DATA'(8'h25),
            NB_DATA'(8'h26), NB_DATA'(8'h27),
            NB_DATA'(8'h03), NB_DATA'(8'h02): op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end
`else
    assign op_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= WAIT_A;
            o_dato_a    <= '0;
            o_dato_b    <= '0;
            o_operation <= '0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_drop      <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_drop     <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_dato_a <= i_rx_data;
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_dato_b <= i_rx_data;
                        state    <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done && op_ok) begin
                        o_operation <= i_rx_data[NB_OP-1:0];
                        o_busy      <= 1'b1;
                        state       <= CALC;
                    end else if (i_rx_done) begin
                        o_drop <= 1'b1;
                    end
                end
                CALC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    o_drop     <= i_rx_done;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    o_drop <= i_rx_done;
                    // A done pulse alongside our own start belongs to an older transfer.
                    if (i_tx_done && !o_tx_start) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
            endcase
        end
    end

endmodule
